// File: rtl/sram_arb_pkg.sv
// Shared types for the two-requester SRAM-like bus arbiter.
// Requester IDs, arbiter FSM states and transfer-size encodings.
package sram_arb_pkg;

    typedef enum logic {
        ID_INST = 1'b0,
        ID_DATA = 1'b1
    } req_id_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/arb_order_fifo.sv
// In-order FIFO of requester IDs for transactions accepted downstream but not yet answered.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module arb_order_fifo
    import sram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  req_id_t                   push_id,
    input  logic                      pop,
    output req_id_t                   head,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    req_id_t         mem_q [DEPTH];
    req_id_t         mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Next-state: write at tail, advance head, net count change.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= ID_INST;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one downstream SRAM-like port between the I-refill (m0) and D-side (m1) requesters.
// Define ARB_ROUND_ROBIN_EN for alternating priority; otherwise m1 always wins contention.
module sram_bus_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned AW              = 32,
    parameter int unsigned DW              = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic [1:0]    m0_size,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_addr_ok,
    output logic          m0_data_ok,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic [1:0]    m1_size,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_addr_ok,
    output logic          m1_data_ok,
    output logic [DW-1:0] m1_rdata,
    output logic          s_req,
    output logic          s_wr,
    output logic [1:0]    s_size,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic          s_addr_ok,
    input  logic          s_data_ok,
    input  logic [DW-1:0] s_rdata,
    output logic          busy,
    output logic          err_spurious
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;

    state_t         state_q, state_d;
    req_id_t        gnt_id_q, gnt_id_d;
    logic           err_q, err_d;
    req_id_t        winner;
    req_id_t        gnt;
    logic           gnt_req;
    logic           handshake;
    logic           pop;
    req_id_t        head;
    logic           full;
    logic           empty;
    logic [CW-1:0]  count;

`ifdef ARB_ROUND_ROBIN_EN
    req_id_t        prio_q, prio_d;

    // Pointer flips after every accepted request.
    always_comb begin
        prio_d = prio_q;
        if (handshake) begin
            prio_d = (prio_q == ID_DATA) ? ID_INST : ID_DATA;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= ID_DATA;
        end else begin
            prio_q <= prio_d;
        end
    end

    always_comb begin
        winner = ID_INST;
        if (m0_req && m1_req) begin
            winner = prio_q;
        end else if (m1_req) begin
            winner = ID_DATA;
        end
    end
`else
    always_comb begin
        winner = ID_INST;
        if (m1_req) begin
            winner = ID_DATA;
        end
    end
`endif

    // HOLD FSM, request mux and accept strobes; everything quiet while rst is high.
    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        gnt        = (state_q == HOLD) ? gnt_id_q : winner;
        gnt_req    = (gnt == ID_DATA) ? m1_req : m0_req;
        s_req      = gnt_req & ~full & ~rst;
        handshake  = s_req & s_addr_ok;
        m0_addr_ok = handshake & (gnt == ID_INST);
        m1_addr_ok = handshake & (gnt == ID_DATA);
        s_wr       = 1'b0;
        s_size     = 2'd0;
        s_addr     = '0;
        s_wdata    = '0;
        if (!rst) begin
            s_wr    = (gnt == ID_DATA) ? m1_wr    : m0_wr;
            s_size  = (gnt == ID_DATA) ? m1_size  : m0_size;
            s_addr  = (gnt == ID_DATA) ? m1_addr  : m0_addr;
            s_wdata = (gnt == ID_DATA) ? m1_wdata : m0_wdata;
        end
        case (state_q)
            IDLE: begin
                if (s_req && !s_addr_ok) begin
                    state_d  = HOLD;
                    gnt_id_d = gnt;
                end
            end
            HOLD: begin
                if (handshake || !gnt_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response demux from the FIFO head; an unmatched response is flagged sticky.
    always_comb begin
        pop        = s_data_ok & ~empty & ~rst;
        m0_data_ok = pop & (head == ID_INST);
        m1_data_ok = pop & (head == ID_DATA);
        err_d      = err_q | (s_data_ok & empty);
    end

    assign m0_rdata     = s_rdata;
    assign m1_rdata     = s_rdata;
    assign busy         = (count != '0);
    assign err_spurious = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_id_q <= ID_DATA;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            err_q    <= err_d;
        end
    end

    arb_order_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_order_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (handshake),
        .push_id (gnt),
        .pop     (pop),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

endmodule
